// File: rtl/fourteen_to_one_serializer.sv
// 14-bit parallel-to-serial transmitter: MSB-first frame bracketed by active-low ss,
// with a programmable lead before the first bit and a guaranteed ss-high gap after.
module fourteen_to_one_serializer #(
  parameter int unsigned LEAD_CYCLES = 1,  // 1..15
  parameter int unsigned GAP_CYCLES  = 2   // 1..15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [13:0] data_in,
  output logic        ss,
  output logic        data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [3:0] LEAD_INIT = 4'(LEAD_CYCLES - 1);
  localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [13:0] shreg;
  logic [3:0]  bit_cnt;
  logic [3:0]  ival_cnt;

  // Outputs are assigned alongside the state transition so they reflect the
  // state being entered, not the one being left.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: shreg and counters are cleared too, so a frame abandoned by reset
      // leaves nothing behind that could leak into the next one.
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ival_cnt <= '0;
      ss       <= 1'b1;
      data_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge values
      // of shreg and the counters regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LEAD;
            shreg    <= data_in;
            ival_cnt <= LEAD_INIT;
            ss       <= 1'b0;
            data_out <= data_in[13];
            busy     <= 1'b1;
          end
        end

        LEAD: begin
          if (ival_cnt == 4'd0) begin
            state   <= SHIFT;
            bit_cnt <= 4'd13;
          end else begin
            ival_cnt <= ival_cnt - 4'd1;
          end
        end

        SHIFT: begin
          shreg   <= {shreg[12:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd0) begin
            state    <= GAP;
            ival_cnt <= GAP_INIT;
            ss       <= 1'b1;
            data_out <= 1'b0;
            done     <= 1'b1;
          end else begin
            data_out <= shreg[12];  // bit that becomes shreg[13] after this shift
          end
        end

        GAP: begin
          if (ival_cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ival_cnt <= ival_cnt - 4'd1;
          end
        end

        default: begin
          state    <= IDLE;
          ss       <= 1'b1;
          data_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fourteen_to_one_serializer.sv
// Directed bench for fourteen_to_one_serializer: default instance plus a LEAD=3/GAP=1
// instance sharing the same stimulus; outputs sampled on the falling clock edge.
module tb_fourteen_to_one_serializer;

  logic        clock  = 1'b0;
  logic        clk_en = 1'b0;
  logic        resetn = 1'b1;
  logic        start  = 1'b0;
  logic        sel2   = 1'b0;
  logic [13:0] data_in = '0;

  logic ss1, do1, busy1, done1;
  logic ss2, do2, busy2, done2;

  int vectors     = 0;
  int miscompares = 0;

  logic s_ss[64], s_do[64], s_busy[64], s_done[64];

  fourteen_to_one_serializer dut1 (
    .clock(clock), .resetn(resetn), .start(start), .data_in(data_in),
    .ss(ss1), .data_out(do1), .busy(busy1), .done(done1)
  );

  fourteen_to_one_serializer #(.LEAD_CYCLES(3), .GAP_CYCLES(1)) dut2 (
    .clock(clock), .resetn(resetn), .start(start), .data_in(data_in),
    .ss(ss2), .data_out(do2), .busy(busy2), .done(done2)
  );

  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sample k is taken after edge E0+k; start for the next edge comes from start_prog[k+1].
  task automatic capture(input int n, input logic [63:0] start_prog,
                         input int chg_at, input logic [13:0] chg_data);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      s_ss[k]   = sel2 ? ss2   : ss1;
      s_do[k]   = sel2 ? do2   : do1;
      s_busy[k] = sel2 ? busy2 : busy1;
      s_done[k] = sel2 ? done2 : done1;
      if (k == chg_at) data_in = chg_data;
      start = (k + 1 < 64) ? start_prog[k+1] : 1'b0;
    end
  endtask

  function automatic logic [13:0] word_at(input int base);
    logic [13:0] w;
    for (int i = 0; i < 14; i++) w[13-i] = s_do[base+i];
    return w;
  endfunction

  function automatic int cnt_ss_low(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (s_ss[k] === 1'b0) c++;
    return c;
  endfunction

  function automatic int cnt_ss_high(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (s_ss[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (s_done[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (s_busy[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_fall(input int from);
    for (int k = from; k < 64; k++)
      if (s_ss[k-1] === 1'b1 && s_ss[k] === 1'b0) return k;
    return -1;
  endfunction

  initial begin
    // Reset with the clock stopped
    #1 resetn = 1'b0;
    #1;
    check("reset_ss",       ss1,   1);
    check("reset_data_out", do1,   0);
    check("reset_busy",     busy1, 0);
    check("reset_done",     done1, 0);
    check("reset_ss_p",     ss2,   1);
    clk_en = 1'b1;
    idle(2);
    resetn = 1'b1;
    idle(2);

    // Single frame, defaults: lead at sample 0, slots at 1..14, done at 15
    sel2 = 1'b0; data_in = 14'h2A5C; start = 1'b1;
    capture(20, 64'h1, -1, '0);
    check("single_lead_bit",  s_do[0],          1);
    check("single_word",      word_at(1),       14'h2A5C);
    check("single_ss_low",    cnt_ss_low(0, 19), 15);
    check("single_ss_rise",   s_ss[15],         1);
    check("single_done_at",   s_done[15],       1);
    check("single_done_cnt",  cnt_done(0, 19),  1);
    check("single_gap_do",    s_do[15],         0);
    check("single_busy_16",   s_busy[16],       1);
    check("single_busy_17",   s_busy[17],       0);
    idle(3);

    // start pulsed again during SHIFT with different data: ignored
    data_in = 14'h3FFF; start = 1'b1;
    capture(40, 64'h41, 5, 14'h0000);
    check("busy_word",        word_at(1),        14'h3FFF);
    check("busy_ss_low",      cnt_ss_low(0, 39), 15);
    check("busy_done_cnt",    cnt_done(0, 39),   1);
    idle(3);

    // Back-to-back with start held high
    data_in = 14'h0001; start = 1'b1;
    capture(40, '1, 5, 14'h2000);
    start = 1'b0;
    check("b2b_word1",        word_at(1),         14'h0001);
    check("b2b_slot13",       s_do[14],           1);
    check("b2b_period",       first_fall(1),      18);
    check("b2b_gap_high",     cnt_ss_high(0, 32), 3);
    check("b2b_word2",        word_at(19),        14'h2000);
    check("b2b_slot0",        s_do[19],           1);
    check("b2b_done_cnt",     cnt_done(0, 39),    2);
    idle(25);

    // Asynchronous reset during slot 6
    data_in = 14'h1555; start = 1'b1;
    capture(8, 64'h1, -1, '0);
    check("mid_pre_ss",       s_ss[7],      0);
    check("mid_pre_slots",    {s_do[1], s_do[2], s_do[3], s_do[4], s_do[5], s_do[6], s_do[7]}, 7'b0101010);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_ss",       ss1,   1);
    check("mid_rst_busy",     busy1, 0);
    check("mid_rst_do",       do1,   0);
    idle(2);
    check("mid_rst_done",     done1, 0);
    resetn = 1'b1;
    idle(1);
    data_in = 14'h0AAA; start = 1'b1;
    capture(20, 64'h1, -1, '0);
    check("post_rst_word",    word_at(1),        14'h0AAA);
    check("post_rst_ss_low",  cnt_ss_low(0, 19), 15);
    check("post_rst_done",    cnt_done(0, 19),   1);
    idle(3);

    // LEAD_CYCLES=3, GAP_CYCLES=1 instance, start held high
    sel2 = 1'b1; data_in = 14'h2001; start = 1'b1;
    capture(40, '1, -1, '0);
    start = 1'b0;
    check("p_lead_do",        {s_do[0], s_do[1], s_do[2]}, 3'b111);
    check("p_word",           word_at(3),         14'h2001);
    check("p_ss_low",         cnt_ss_low(0, 18),  17);
    check("p_done_at",        s_done[17],         1);
    check("p_busy_high",      cnt_busy(0, 18),    18);
    check("p_busy_18",        s_busy[18],         0);
    check("p_period",         first_fall(1),      19);
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
